// File: rtl/store_commit_buffer.sv
// rtl/store_commit_buffer.sv - committed-store FIFO feeding DataMemory with byte-granular load forwarding
module store_commit_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ROB_MemWrite,
    input  logic [31:0]      ROB_memadress,
    input  logic [2:0]       ROB_funct3,
    input  logic [31:0]      ROB_store_data,
    output logic             sb_full,
    output logic             sb_empty,
    output logic [PTR_W:0]   sb_count,
    output logic             sb_overflow,
    input  logic             mem_ready,
    output logic             MemWrite_out,
    output logic [31:0]      mem_addr_out,
    output logic [2:0]       mem_funct3_out,
    output logic [31:0]      mem_data_out,
    input  logic             LS_MemRead,
    input  logic [31:0]      LS_result,
    input  logic [2:0]       func3_LS,
    output logic             fwd_hit,
    output logic             fwd_stall,
    output logic [31:0]      fwd_data
);

    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      addr_d [DEPTH];
    logic [2:0]       f3_q   [DEPTH];
    logic [2:0]       f3_d   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;

    logic             st_f3_ok;
    logic             enq;
    logic             pop;

    function automatic logic [2:0] st_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   st_size = 3'd1;
            2'b01:   st_size = 3'd2;
            default: st_size = 3'd4;
        endcase
    endfunction

    assign sb_full      = (count_q == (PTR_W + 1)'(DEPTH));
    assign sb_empty     = (count_q == '0);
    assign sb_count     = count_q;
    assign sb_overflow  = overflow_q;

    assign MemWrite_out   = !sb_empty;
    assign mem_addr_out   = sb_empty ? 32'd0 : addr_q[rd_ptr_q];
    assign mem_funct3_out = sb_empty ? 3'd0  : f3_q[rd_ptr_q];
    assign mem_data_out   = sb_empty ? 32'd0 : data_q[rd_ptr_q];

    assign st_f3_ok = (ROB_funct3 == 3'b000) || (ROB_funct3 == 3'b001) || (ROB_funct3 == 3'b010);
    assign enq      = ROB_MemWrite && !sb_full && st_f3_ok;
    assign pop      = MemWrite_out && mem_ready;

    always_comb begin
        addr_d     = addr_q;
        f3_d       = f3_q;
        data_d     = data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || (ROB_MemWrite && sb_full);

        if (enq) begin
            addr_d[wr_ptr_q] = ROB_memadress;
            f3_d[wr_ptr_q]   = ROB_funct3;
            data_d[wr_ptr_q] = ROB_store_data;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({enq, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            f3_q       <= f3_d;
            data_q     <= data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    logic [2:0]       ld_size;
    logic             ld_signed;
    logic [3:0]       need;
    logic [3:0]       cov;
    logic [7:0]       fbyte [4];
    logic [31:0]      byte_addr;
    logic [31:0]      off;
    logic [PTR_W-1:0] idx;
    logic             all_cov;
    logic             any_cov;
    logic [31:0]      ext_data;

    // Entries are scanned oldest to youngest so the youngest covering store wins each byte.
    always_comb begin
        ld_size   = 3'd0;
        ld_signed = 1'b0;
        need      = '0;
        cov       = '0;
        byte_addr = '0;
        off       = '0;
        idx       = '0;
        for (int k = 0; k < 4; k++) begin
            fbyte[k] = 8'd0;
        end

        case (func3_LS)
            3'b000:  begin ld_size = 3'd1; ld_signed = 1'b1; end
            3'b001:  begin ld_size = 3'd2; ld_signed = 1'b1; end
            3'b010:  begin ld_size = 3'd4; ld_signed = 1'b0; end
            3'b100:  begin ld_size = 3'd1; ld_signed = 1'b0; end
            3'b101:  begin ld_size = 3'd2; ld_signed = 1'b0; end
            default: begin ld_size = 3'd0; ld_signed = 1'b0; end
        endcase

        for (int k = 0; k < 4; k++) begin
            need[k]   = (3'(k) < ld_size);
            byte_addr = LS_result + 32'(k);
            for (int j = 0; j < DEPTH; j++) begin
                if (j < int'(count_q)) begin
                    idx = rd_ptr_q + PTR_W'(j);
                    off = byte_addr - addr_q[idx];
                    if (off < {29'd0, st_size(f3_q[idx])}) begin
                        cov[k]   = 1'b1;
                        fbyte[k] = 8'(data_q[idx] >> {off[1:0], 3'b000});
                    end
                end
            end
        end
    end

    assign all_cov = ((cov & need) == need);
    assign any_cov = |(cov & need);

    always_comb begin
        case (ld_size)
            3'd1:    ext_data = {{24{ld_signed & fbyte[0][7]}}, fbyte[0]};
            3'd2:    ext_data = {{16{ld_signed & fbyte[1][7]}}, fbyte[1], fbyte[0]};
            default: ext_data = {fbyte[3], fbyte[2], fbyte[1], fbyte[0]};
        endcase
    end

    // need is non-zero for every supported load type, so all_cov implies any_cov there.
    assign fwd_hit   = LS_MemRead && (ld_size != 3'd0) && all_cov;
    assign fwd_stall = LS_MemRead && (ld_size != 3'd0) && any_cov && !all_cov;
    assign fwd_data  = fwd_hit ? ext_data : 32'd0;

endmodule

// File: tb/tb_store_commit_buffer.sv
// tb/tb_store_commit_buffer.sv - self-checking bench for store_commit_buffer
module tb_store_commit_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ROB_MemWrite;
    logic [31:0] ROB_memadress;
    logic [2:0]  ROB_funct3;
    logic [31:0] ROB_store_data;
    logic        sb_full;
    logic        sb_empty;
    logic [2:0]  sb_count;
    logic        sb_overflow;
    logic        mem_ready;
    logic        MemWrite_out;
    logic [31:0] mem_addr_out;
    logic [2:0]  mem_funct3_out;
    logic [31:0] mem_data_out;
    logic        LS_MemRead;
    logic [31:0] LS_result;
    logic [2:0]  func3_LS;
    logic        fwd_hit;
    logic        fwd_stall;
    logic [31:0] fwd_data;

    store_commit_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .ROB_MemWrite(ROB_MemWrite), .ROB_memadress(ROB_memadress),
        .ROB_funct3(ROB_funct3), .ROB_store_data(ROB_store_data),
        .sb_full(sb_full), .sb_empty(sb_empty), .sb_count(sb_count),
        .sb_overflow(sb_overflow), .mem_ready(mem_ready),
        .MemWrite_out(MemWrite_out), .mem_addr_out(mem_addr_out),
        .mem_funct3_out(mem_funct3_out), .mem_data_out(mem_data_out),
        .LS_MemRead(LS_MemRead), .LS_result(LS_result), .func3_LS(func3_LS),
        .fwd_hit(fwd_hit), .fwd_stall(fwd_stall), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] data;
    } st_t;

    typedef struct {
        logic        mr;
        logic [31:0] a;
        logic [2:0]  f3;
        logic        hit;
        logic        stall;
        logic [31:0] data;
    } fwd_vec_t;

    st_t      sb_q[$];
    fwd_vec_t tv[15];
    logic     ov_m;
    int       checks = 0;
    int       errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ROB_MemWrite = 1'b0; ROB_memadress = '0; ROB_funct3 = '0; ROB_store_data = '0;
        mem_ready = 1'b0; LS_MemRead = 1'b0; LS_result = '0; func3_LS = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        sb_q.delete();
        ov_m = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_count"},    32'(sb_count),     32'(sb_q.size()));
        chk({tag, "_full"},     32'(sb_full),      32'(sb_q.size() == 4));
        chk({tag, "_empty"},    32'(sb_empty),     32'(sb_q.size() == 0));
        chk({tag, "_memwrite"}, 32'(MemWrite_out), 32'(sb_q.size() != 0));
        chk({tag, "_overflow"}, 32'(sb_overflow),  32'(ov_m));
    endtask

    // One clock: the head is scored if memory accepts it, then the model takes the enqueue.
    task automatic step(input logic mw, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] d, input logic rdy);
        int  pre;
        st_t e;
        ROB_MemWrite = mw; ROB_memadress = a; ROB_funct3 = f3; ROB_store_data = d;
        mem_ready = rdy;
        #1;
        pre = sb_q.size();
        if (rdy && pre > 0) begin
            e = sb_q.pop_front();
            chk("pop_valid", 32'(MemWrite_out), 32'd1);
            chk("pop_addr", mem_addr_out, e.addr);
            chk("pop_f3", 32'(mem_funct3_out), 32'(e.f3));
            chk("pop_data", mem_data_out, e.data);
        end
        if (mw && pre == 4) ov_m = 1'b1;
        if (mw && pre < 4 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010)) begin
            e.addr = a; e.f3 = f3; e.data = d;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        ROB_MemWrite = 1'b0; mem_ready = 1'b0;
        chk_state("step");
    endtask

    task automatic lookup(input string tag, input logic mr, input logic [31:0] a,
                          input logic [2:0] f3, input logic hit, input logic stall,
                          input logic [31:0] data);
        LS_MemRead = mr; LS_result = a; func3_LS = f3;
        #1;
        chk({tag, "_hit"},   32'(fwd_hit),   32'(hit));
        chk({tag, "_stall"}, 32'(fwd_stall), 32'(stall));
        chk({tag, "_data"},  fwd_data,       data);
    endtask

    initial begin
        tv[0]  = '{1'b1, 32'h0000_0200, 3'b000, 1'b1, 1'b0, 32'hFFFF_FF80};
        tv[1]  = '{1'b1, 32'h0000_0200, 3'b100, 1'b1, 1'b0, 32'h0000_0080};
        tv[2]  = '{1'b1, 32'h0000_0300, 3'b010, 1'b0, 1'b1, 32'h0000_0000};
        tv[3]  = '{1'b1, 32'h0000_0400, 3'b010, 1'b0, 1'b0, 32'h0000_0000};
        tv[4]  = '{1'b1, 32'h0000_0300, 3'b001, 1'b1, 1'b0, 32'hFFFF_ABCD};
        tv[5]  = '{1'b1, 32'h0000_0300, 3'b101, 1'b1, 1'b0, 32'h0000_ABCD};
        tv[6]  = '{1'b1, 32'h0000_0301, 3'b000, 1'b1, 1'b0, 32'hFFFF_FFAB};
        tv[7]  = '{1'b1, 32'h0000_0301, 3'b001, 1'b0, 1'b1, 32'h0000_0000};
        tv[8]  = '{1'b1, 32'hFFFF_FFFE, 3'b010, 1'b1, 1'b0, 32'h4433_2211};
        tv[9]  = '{1'b1, 32'hFFFF_FFFF, 3'b001, 1'b1, 1'b0, 32'h0000_3322};
        tv[10] = '{1'b1, 32'h0000_01FF, 3'b010, 1'b0, 1'b1, 32'h0000_0000};
        tv[11] = '{1'b1, 32'h0000_0200, 3'b011, 1'b0, 1'b0, 32'h0000_0000};
        tv[12] = '{1'b0, 32'h0000_0200, 3'b000, 1'b0, 1'b0, 32'h0000_0000};
        tv[13] = '{1'b1, 32'h0000_0001, 3'b000, 1'b1, 1'b0, 32'h0000_0044};
        tv[14] = '{1'b1, 32'h0000_0002, 3'b000, 1'b0, 1'b0, 32'h0000_0000};

        // T1: reset state, then a single SW lands at the head
        do_reset();
        chk_state("reset");
        chk("reset_mem_addr", mem_addr_out, 32'd0);
        chk("reset_mem_data", mem_data_out, 32'd0);
        step(1'b1, 32'h100, 3'b010, 32'hDEAD_BEEF, 1'b0);
        chk("t1_addr", mem_addr_out, 32'h100);
        chk("t1_data", mem_data_out, 32'hDEAD_BEEF);
        chk("t1_f3", 32'(mem_funct3_out), 32'd2);

        // T2: overfill, then drain in order
        do_reset();
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h1000 + 32'(4 * i), 3'b010, 32'hA000_0000 + 32'(i), 1'b0);
        chk("t2_overflow", 32'(sb_overflow), 32'd1);
        step(1'b1, 32'h2000, 3'b011, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 3'b000, 32'h0, 1'b1);

        // T3/T4 and wrap cases: forwarding table against a full buffer
        do_reset();
        step(1'b1, 32'h200, 3'b000, 32'h0000_0011, 1'b0);
        step(1'b1, 32'h200, 3'b000, 32'h0000_0080, 1'b0);
        step(1'b1, 32'h300, 3'b001, 32'h0000_ABCD, 1'b0);
        step(1'b1, 32'hFFFF_FFFE, 3'b010, 32'h4433_2211, 1'b0);
        for (int i = 0; i < 15; i++)
            lookup($sformatf("fwd%0d", i), tv[i].mr, tv[i].a, tv[i].f3,
                   tv[i].hit, tv[i].stall, tv[i].data);
        LS_MemRead = 1'b0;

        // T5: steady enqueue+pop with two entries resident
        do_reset();
        step(1'b1, 32'h5000, 3'b010, 32'h1111_0000, 1'b0);
        step(1'b1, 32'h5004, 3'b001, 32'h2222_0001, 1'b0);
        for (int i = 0; i < 8; i++)
            step(1'b1, 32'h6000 + 32'(i), 3'(i % 3), $urandom, 1'b1);
        step(1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
        step(1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
        step(1'b0, 32'h0, 3'b000, 32'h0, 1'b1);

        // Popping entry still forwards; same-cycle enqueue does not
        step(1'b1, 32'h600, 3'b000, 32'h0000_007F, 1'b0);
        ROB_MemWrite = 1'b1; ROB_memadress = 32'h700; ROB_funct3 = 3'b000;
        ROB_store_data = 32'h55; mem_ready = 1'b1;
        lookup("popfwd", 1'b1, 32'h600, 3'b000, 1'b1, 1'b0, 32'h7F);
        lookup("enqfwd", 1'b1, 32'h700, 3'b000, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h700, 3'b000, 32'h55, 1'b1);
        lookup("afterfwd", 1'b1, 32'h700, 3'b100, 1'b1, 1'b0, 32'h55);
        LS_MemRead = 1'b0;

        // T6: reset beats a pending drain
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h7000 + 32'(4 * i), 3'b010, 32'(i), 1'b0);
        reset = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b0;
        sb_q.delete(); ov_m = 1'b0;
        chk_state("t6");
        chk("t6_mem_addr", mem_addr_out, 32'd0);
        step(1'b1, 32'h8000, 3'b010, 32'h1234_5678, 1'b0);
        step(1'b0, 32'h0, 3'b000, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
